// File: rtl/fft4_frame_loader_if.sv
// Stream-in / frame-out bundle between the sample source, the loader and the FFT core.
// master: the environment (sample producer plus FFT core). slave: the loader itself.
interface fft4_frame_loader_if #(
  parameter int unsigned WIDTH = 16
);
  // Sample stream
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_real;
  logic [WIDTH-1:0] in_imag;
  logic             in_last;

  // Parallel frame towards the FFT core, index = arrival order
  logic [WIDTH-1:0] x_real_0;
  logic [WIDTH-1:0] x_real_1;
  logic [WIDTH-1:0] x_real_2;
  logic [WIDTH-1:0] x_real_3;
  logic [WIDTH-1:0] x_imag_0;
  logic [WIDTH-1:0] x_imag_1;
  logic [WIDTH-1:0] x_imag_2;
  logic [WIDTH-1:0] x_imag_3;

  // Core handshake and status
  logic             fft_start;
  logic             fft_done;
  logic             frame_err;
  logic             timeout;
  logic             busy;

  modport master (
    output in_valid, in_real, in_imag, in_last, fft_done,
    input  in_ready,
    input  x_real_0, x_real_1, x_real_2, x_real_3,
    input  x_imag_0, x_imag_1, x_imag_2, x_imag_3,
    input  fft_start, frame_err, timeout, busy
  );

  modport slave (
    input  in_valid, in_real, in_imag, in_last, fft_done,
    output in_ready,
    output x_real_0, x_real_1, x_real_2, x_real_3,
    output x_imag_0, x_imag_1, x_imag_2, x_imag_3,
    output fft_start, frame_err, timeout, busy
  );
endinterface

// File: rtl/fft4_frame_loader.sv
// Frame loader for the 4-point FFT core: collects four serial complex samples into a
// fill buffer, hands complete frames over as stable parallel words with a start pulse,
// and waits (bounded by a watchdog) for the core to report done.
module fft4_frame_loader #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DONE_TIMEOUT = 15  // must be >= 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fft4_frame_loader_if.slave bus
);

  // Watchdog only ever holds 0..DONE_TIMEOUT-1.
  localparam int unsigned WdW = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(DONE_TIMEOUT - 1);

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } ostate_e;

  typedef logic [3:0][WIDTH-1:0] frame_word_t;

  // Fill side
  logic [1:0]  cnt_q, cnt_d;
  logic        full_q, full_d;
  frame_word_t fill_re_q, fill_re_d;
  frame_word_t fill_im_q, fill_im_d;
  logic        frame_err_q, frame_err_d;

  // Output side
  ostate_e     state_q, state_d;
  frame_word_t x_re_q, x_re_d;
  frame_word_t x_im_q, x_im_d;
  logic        fft_start_q, fft_start_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic [WdW-1:0] wd_q, wd_d;

  logic accept;

  // Fill buffer accept / alignment check, then the output FSM next state.
  always_comb begin
    cnt_d       = cnt_q;
    full_d      = full_q;
    fill_re_d   = fill_re_q;
    fill_im_d   = fill_im_q;
    frame_err_d = 1'b0;
    state_d     = state_q;
    x_re_d      = x_re_q;
    x_im_d      = x_im_q;
    fft_start_d = 1'b0;
    timeout_d   = 1'b0;
    busy_d      = busy_q;
    wd_d        = wd_q;

    accept = bus.in_valid && !full_q;

    if (accept) begin
      if (cnt_q == 2'd3) begin
        cnt_d = 2'd0;
        if (bus.in_last) begin
          fill_re_d[3] = bus.in_real;
          fill_im_d[3] = bus.in_imag;
          full_d       = 1'b1;
        end else begin
          // Four samples without a frame marker: the whole frame is suspect.
          frame_err_d = 1'b1;
        end
      end else if (bus.in_last) begin
        // Early marker: drop the partial frame together with this sample.
        cnt_d       = 2'd0;
        frame_err_d = 1'b1;
      end else begin
        fill_re_d[cnt_q] = bus.in_real;
        fill_im_d[cnt_q] = bus.in_imag;
        cnt_d            = cnt_q + 2'd1;
      end
    end

    // accept needs !full and the transfer needs full, so full_d never sees both.
    unique case (state_q)
      StIdle: begin
        if (full_q) begin
          x_re_d      = fill_re_q;
          x_im_d      = fill_im_q;
          full_d      = 1'b0;
          fft_start_d = 1'b1;
          busy_d      = 1'b1;
          wd_d        = '0;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        wd_d = wd_q + WdW'(1);
        if (bus.fft_done) begin
          busy_d  = 1'b0;
          wd_d    = '0;
          state_d = StIdle;
        end else if (wd_q == WdLast) begin
          // Core is stalled; abandon the frame so the next one can go.
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          wd_d      = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= 2'd0;
      full_q      <= 1'b0;
      fill_re_q   <= '0;
      fill_im_q   <= '0;
      frame_err_q <= 1'b0;
      state_q     <= StIdle;
      x_re_q      <= '0;
      x_im_q      <= '0;
      fft_start_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      wd_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      fill_re_q   <= fill_re_d;
      fill_im_q   <= fill_im_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      x_re_q      <= x_re_d;
      x_im_q      <= x_im_d;
      fft_start_q <= fft_start_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.in_ready  = !full_q;
  assign bus.x_real_0  = x_re_q[0];
  assign bus.x_real_1  = x_re_q[1];
  assign bus.x_real_2  = x_re_q[2];
  assign bus.x_real_3  = x_re_q[3];
  assign bus.x_imag_0  = x_im_q[0];
  assign bus.x_imag_1  = x_im_q[1];
  assign bus.x_imag_2  = x_im_q[2];
  assign bus.x_imag_3  = x_im_q[3];
  assign bus.fft_start = fft_start_q;
  assign bus.frame_err = frame_err_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fft4_frame_loader.sv
// Bench for fft4_frame_loader: directed scenarios followed by random frames, checked by a
// negedge monitor that also plays the FFT core and keeps a frame-level reference model.
module tb_fft4_frame_loader;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft4_frame_loader_if #(.WIDTH(W)) bus ();

  fft4_frame_loader #(
    .WIDTH       (W),
    .DONE_TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0][W-1:0] re;
    logic [3:0][W-1:0] im;
  } frame_t;

  // Scoreboard
  frame_t       frame_q[$];  // complete frames awaiting fft_start
  int           ready_q[$];  // first cycle in which each of those frames is full
  int           err_q[$];    // cycles in which frame_err must pulse
  logic [W-1:0] part_re[$];
  logic [W-1:0] part_im[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Monitor / core model state
  bit     core_busy = 1'b0;
  bit     no_done   = 1'b0;
  bit     prev_idle = 1'b1;
  bit     prev_start = 1'b0;
  bit     rst_prev  = 1'b0;
  int     start_cyc = 0;
  int     done_cyc  = 0;
  int     nframes   = 0;
  frame_t held      = '0;
  frame_t f;
  logic   exp_s, exp_to, exp_err, exp_rdy;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    ready_q.delete();
    err_q.delete();
    part_re.delete();
    part_im.delete();
    core_busy  = 1'b0;
    prev_idle  = 1'b1;
    prev_start = 1'b0;
    held       = '0;
  endtask

  // Monitor and FFT-core model, sampling mid-cycle.
  initial begin
    bus.fft_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        model_reset();
        bus.fft_done = 1'b0;
        rst_prev = 1'b1;
      end else begin
        if (rst_prev) begin
          rst_prev = 1'b0;
          chk("reset_flags", {bus.fft_start, bus.frame_err, bus.timeout, bus.busy}, 4'b0);
        end

        // Done was presented last cycle, so the loader is idle now.
        if (bus.fft_done) begin
          bus.fft_done = 1'b0;
          core_busy = 1'b0;
        end

        exp_to = core_busy && no_done && (cyc == start_cyc + TO);
        if (bus.timeout || exp_to) chk("timeout", bus.timeout, exp_to);
        if (exp_to) core_busy = 1'b0;

        // A full frame is transferred on the first edge that finds the loader idle.
        exp_s = prev_idle && (frame_q.size() > 0) && (ready_q[0] <= cyc - 1);
        if (bus.fft_start || exp_s) chk("fft_start", bus.fft_start, exp_s);
        if (bus.fft_start) chk("start_one_cycle", prev_start, 1'b0);
        prev_start = bus.fft_start;
        if (exp_s) begin
          f = frame_q.pop_front();
          void'(ready_q.pop_front());
          chk("x_real", {bus.x_real_3, bus.x_real_2, bus.x_real_1, bus.x_real_0}, f.re);
          chk("x_imag", {bus.x_imag_3, bus.x_imag_2, bus.x_imag_1, bus.x_imag_0}, f.im);
          held      = f;
          core_busy = 1'b1;
          start_cyc = cyc;
          no_done   = (nframes % 4 == 2);
          done_cyc  = cyc + int'($urandom_range(1, 5));
          nframes++;
        end else begin
          chk("x_hold",
              {bus.x_real_3, bus.x_real_2, bus.x_real_1, bus.x_real_0,
               bus.x_imag_3, bus.x_imag_2, bus.x_imag_1, bus.x_imag_0},
              {held.re, held.im});
        end

        chk("busy", bus.busy, core_busy);

        if (core_busy && !no_done && cyc == done_cyc) begin
          bus.fft_done = 1'b1;
        end else if (!core_busy && $urandom_range(0, 9) == 0) begin
          // Stray done while idle must be ignored.
          bus.fft_done = 1'b1;
        end

        exp_rdy = !((frame_q.size() > 0) && (ready_q[0] <= cyc));
        chk("in_ready", bus.in_ready, exp_rdy);

        exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
        if (bus.frame_err || exp_err) chk("frame_err", bus.frame_err, exp_err);
        if (exp_err) void'(err_q.pop_front());

        // Reference framing: four samples, marker exactly on the fourth.
        if (bus.in_valid && bus.in_ready) begin
          part_re.push_back(bus.in_real);
          part_im.push_back(bus.in_imag);
          if (bus.in_last || part_re.size() == 4) begin
            if (bus.in_last && part_re.size() == 4) begin
              for (int k = 0; k < 4; k++) begin
                f.re[k] = part_re[k];
                f.im[k] = part_im[k];
              end
              frame_q.push_back(f);
              ready_q.push_back(cyc + 1);
            end else begin
              err_q.push_back(cyc + 1);
            end
            part_re.delete();
            part_im.delete();
          end
        end
        prev_idle = !core_busy;
      end
    end
  end

  task automatic send(input logic [W-1:0] r, input logic [W-1:0] im, input logic last);
    bit acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_real  = r;
    bus.in_imag  = im;
    bus.in_last  = last;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_stall: in_ready stayed 0 for 200 cycles, required 1");
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic good_frame(input bit gaps);
    for (int i = 0; i < 4; i++) begin
      send(W'($urandom), W'($urandom), i == 3);
      if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    int kind;
    int len;
    bus.in_valid = 1'b0;
    bus.in_real  = '0;
    bus.in_imag  = '0;
    bus.in_last  = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Simple ramp frame
    for (int i = 1; i <= 4; i++) send(W'(i), W'(-i), i == 4);
    idle(12);

    // Two frames back to back with in_valid held high
    good_frame(1'b0);
    good_frame(1'b0);
    idle(25);

    // Marker on 2nd sample, then a clean frame 5..8
    send(W'(9), W'(9), 1'b0);
    send(W'(10), W'(10), 1'b1);
    for (int i = 5; i <= 8; i++) send(W'(i), W'(-i), i == 8);
    idle(12);

    // Four samples without a marker, then a clean frame
    for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), 1'b0);
    good_frame(1'b0);
    idle(25);

    // Reset after the 2nd sample of a frame, then a full frame from slot 0
    send(W'(11), W'(12), 1'b0);
    send(W'(13), W'(14), 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    good_frame(1'b0);
    idle(25);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 7) begin
        good_frame(1'b1);
      end else if (kind < 9) begin
        len = int'($urandom_range(1, 3));
        for (int i = 0; i < len; i++) send(W'($urandom), W'($urandom), i == len - 1);
      end else begin
        for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), 1'b0);
      end
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 6)));
    end
    idle(60);

    chk("frames_drained", 128'(frame_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
